// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: function codes and the arbiter FSM state encoding.
package alu_pkg;

  localparam int unsigned ALU_FUNC_W = 3;

  localparam logic [ALU_FUNC_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_FUNC_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_FUNC_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_FUNC_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_FUNC_W-1:0] ALU_SLT = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Flags function codes beyond SLT; the ALU yields 0 for these.
  function automatic logic func_is_illegal(input logic [ALU_FUNC_W-1:0] func);
    return func > ALU_SLT;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin arbiter: one-hot grant searched from ptr upward with wrap.
module rr_arbiter #(
  parameter  int unsigned N    = 2,
  localparam int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = ID_W'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external ALU among NUM_REQ requesters (IDLE/EXEC/RESP).
// Optional ALU_ARB_ILLEGAL_OP_EN adds rsp_err flagging function codes above SLT.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  parameter  int unsigned DATA_W  = 32,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]    req_a,
  input  logic [NUM_REQ*DATA_W-1:0]    req_b,
  input  logic [NUM_REQ*ALU_FUNC_W-1:0] req_func,
  output logic [DATA_W-1:0]            alu_a,
  output logic [DATA_W-1:0]            alu_b,
  output logic [ALU_FUNC_W-1:0]        alu_func,
  input  logic [DATA_W-1:0]            alu_result,
  input  logic                         alu_zero,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [DATA_W-1:0]            rsp_result,
  output logic                         rsp_zero,
  output logic                         busy
`ifdef ALU_ARB_ILLEGAL_OP_EN
  ,
  output logic                         rsp_err
`endif
);

  arb_state_e            state, state_d;
  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       gnt_id;
  logic [ID_W-1:0]       ptr_q;
  logic [ID_W-1:0]       id_q;
  logic [ID_W-1:0]       ptr_nxt;
  logic [DATA_W-1:0]     a_q, b_q, result_q;
  logic [ALU_FUNC_W-1:0] func_q;
  logic                  zero_q;
  logic                  take;
  logic                  done;

  logic [DATA_W-1:0]     a_arr    [NUM_REQ];
  logic [DATA_W-1:0]     b_arr    [NUM_REQ];
  logic [ALU_FUNC_W-1:0] func_arr [NUM_REQ];

  // Unpack the flat request buses so the winner can be selected by index.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g]    = req_a[g*DATA_W +: DATA_W];
    assign b_arr[g]    = req_b[g*DATA_W +: DATA_W];
    assign func_arr[g] = req_func[g*ALU_FUNC_W +: ALU_FUNC_W];
  end

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_comb begin
    state_d   = state;
    take      = 1'b0;
    done      = 1'b0;
    req_ready = '0;
    case (state)
      IDLE: begin
        req_ready = gnt;
        if (|req_valid) begin
          take    = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Priority rotates to the requester just after the one that was served.
  assign ptr_nxt = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      func_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      if (take) begin
        id_q   <= gnt_id;
        a_q    <= a_arr[gnt_id];
        b_q    <= b_arr[gnt_id];
        func_q <= func_arr[gnt_id];
      end
      if (state == EXEC) begin
        result_q <= alu_result;
        zero_q   <= alu_zero;
      end
      if (done) begin
        ptr_q <= ptr_nxt;
      end
    end
  end

`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == EXEC) begin
      err_q <= func_is_illegal(func_q);
    end
  end

  assign rsp_err = err_q;
`endif

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_func   = func_q;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run against a
// transaction-level model. A behavioural ALU stands in for the external ALU.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N  = 2;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N*3-1:0]  req_func;
  logic [DW-1:0]   alu_a, alu_b, alu_result;
  logic [2:0]      alu_func;
  logic            alu_zero;
  logic            rsp_valid, rsp_ready;
  logic [0:0]      rsp_id;
  logic [DW-1:0]   rsp_result;
  logic            rsp_zero;
  logic            busy;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic            rsp_err;
`endif

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_func   (req_func),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_func   (alu_func),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
`ifdef ALU_ARB_ILLEGAL_OP_EN
    ,
    .rsp_err    (rsp_err)
`endif
  );

  always #5 clk = ~clk;

  // What the external ALU computes for each function code.
  function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [2:0] f);
    case (f)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  always_comb alu_result = alu_ref(alu_a, alu_b, alu_func);
  assign alu_zero = (alu_result == '0);

  // Expected one-hot grant: first valid requester at or after p, wrapping.
  function automatic logic [N-1:0] rr_exp(input int p, input logic [N-1:0] v);
    logic [N-1:0] r;
    int idx;
    r = '0;
    for (int k = 0; k < N; k++) begin
      idx = (p + k) % N;
      if (v[idx]) begin
        r[idx] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [2:0] f);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_func[i*3 +: 3] = f;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_func = '0;
    tick; tick;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_rsp_zero got=%b want=0", rsp_zero); end
    checks++; if (rsp_result !== '0) begin errors++; $display("FAIL reset_rsp_result got=%h want=0", rsp_result); end
    checks++; if (alu_a !== '0 || alu_b !== '0 || alu_func !== 3'b000) begin errors++; $display("FAIL reset_alu_regs got=%h/%h/%b want=0", alu_a, alu_b, alu_func); end
`ifdef ALU_ARB_ILLEGAL_OP_EN
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_add;
    req_valid = 2'b01; set_req(0, 32'd5, 32'd7, ALU_ADD); rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL add_grant got=%b want=01", req_ready); end
    tick; req_valid = '0; #1;
    checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL add_exec got busy=%b vld=%b rdy=%b want 1/0/00", busy, rsp_valid, req_ready); end
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_func !== ALU_ADD) begin errors++; $display("FAIL add_alu_drive got=%0d/%0d/%b want 5/7/000", alu_a, alu_b, alu_func); end
    tick;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_latency got rsp_valid=%b want=1", rsp_valid); end
    checks++; if (rsp_result !== 32'd12 || rsp_zero !== 1'b0 || rsp_id !== 1'b0) begin errors++; $display("FAIL add_rsp got=%0d z=%b id=%0d want 12 z=0 id=0", rsp_result, rsp_zero, rsp_id); end
    tick;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_done got vld=%b busy=%b want 0/0", rsp_valid, busy); end
  endtask

  task automatic test_sub_slt;
    logic [2:0]  f [2];
    logic [DW-1:0] a [2], b [2], r [2];
    logic        z [2];
    f[0] = ALU_SUB; a[0] = 32'd9; b[0] = 32'd9; r[0] = 32'd0; z[0] = 1'b1;
    f[1] = ALU_SLT; a[1] = 32'd3; b[1] = 32'd8; r[1] = 32'd1; z[1] = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid = 2'b10; set_req(1, a[k], b[k], f[k]); #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL subslt_grant%0d got=%b want=10", k, req_ready); end
      tick; req_valid = '0; tick;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1) begin errors++; $display("FAIL subslt_vld%0d got vld=%b id=%0d want 1/1", k, rsp_valid, rsp_id); end
      checks++; if (rsp_result !== r[k] || rsp_zero !== z[k]) begin errors++; $display("FAIL subslt_rsp%0d got=%0d z=%b want %0d z=%b", k, rsp_result, rsp_zero, r[k], z[k]); end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    int acc_cyc[$];
    int acc_id[$];
    logic [DW-1:0] acc_res[$];
    int rsp_cyc[$];
    int rsp_ids[$];
    logic [DW-1:0] rsp_res[$];
    int g;
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (acc_cyc.size() >= 4) req_valid = '0;
      for (int i = 0; i < N; i++) set_req(i, DW'($urandom_range(0, 1000)), DW'($urandom_range(0, 1000)), 3'($urandom_range(0, 4)));
      #1;
      if (|(req_ready & req_valid)) begin
        g = req_ready[1] ? 1 : 0;
        acc_cyc.push_back(c); acc_id.push_back(g);
        acc_res.push_back(alu_ref(req_a[g*DW +: DW], req_b[g*DW +: DW], req_func[g*3 +: 3]));
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cyc.push_back(c); rsp_ids.push_back(int'(rsp_id)); rsp_res.push_back(rsp_result);
      end
      tick;
    end
    checks++; if (acc_cyc.size() != 4 || rsp_cyc.size() != 4) begin errors++; $display("FAIL b2b_count got acc=%0d rsp=%0d want 4/4", acc_cyc.size(), rsp_cyc.size()); end
    for (int k = 0; k < 4 && k < acc_cyc.size() && k < rsp_cyc.size(); k++) begin
      checks++; if (acc_id[k] != k % 2 || rsp_ids[k] != k % 2) begin errors++; $display("FAIL b2b_id%0d got acc=%0d rsp=%0d want %0d", k, acc_id[k], rsp_ids[k], k % 2); end
      checks++; if (rsp_cyc[k] != acc_cyc[k] + 2) begin errors++; $display("FAIL b2b_latency%0d got=%0d want=%0d", k, rsp_cyc[k], acc_cyc[k] + 2); end
      checks++; if (rsp_res[k] !== acc_res[k]) begin errors++; $display("FAIL b2b_result%0d got=%h want=%h", k, rsp_res[k], acc_res[k]); end
      if (k > 0) begin
        checks++; if (acc_cyc[k] - acc_cyc[k-1] != 3) begin errors++; $display("FAIL b2b_spacing%0d got=%0d want=3", k, acc_cyc[k] - acc_cyc[k-1]); end
      end
    end
  endtask

  task automatic test_stall;
    req_valid = 2'b01; set_req(0, 32'h0000_00F0, 32'h0000_000F, ALU_OR); rsp_ready = 1'b0; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_grant got=%b want=01", req_ready); end
    tick; req_valid = 2'b11; #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_exec_ready got=%b want=00", req_ready); end
    tick;
    for (int c = 0; c < 4; c++) begin
      set_req(0, $urandom, $urandom, 3'($urandom_range(0, 7)));
      set_req(1, $urandom, $urandom, 3'($urandom_range(0, 7)));
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'h0000_00FF || rsp_zero !== 1'b0) begin errors++; $display("FAIL stall_hold%0d got vld=%b id=%0d res=%h z=%b want 1/0/ff/0", c, rsp_valid, rsp_id, rsp_result, rsp_zero); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_ready%0d got=%b want=00", c, req_ready); end
      tick;
    end
    rsp_ready = 1'b1; #1;
    checks++; if (rsp_valid !== 1'b1 || req_ready !== 2'b00) begin errors++; $display("FAIL stall_release got vld=%b rdy=%b want 1/00", rsp_valid, req_ready); end
    tick;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin errors++; $display("FAIL stall_after got vld=%b rdy=%b want 0/10", rsp_valid, req_ready); end
    req_valid = '0;
    tick;
  endtask

  task automatic test_reset_mid;
    req_valid = 2'b11; set_req(0, 32'd1, 32'd2, ALU_ADD); set_req(1, 32'd3, 32'd4, ALU_ADD); rsp_ready = 1'b1; #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rstmid_grant got=%b want=10", req_ready); end
    tick; rst = 1'b1; req_valid = '0;
    tick; rst = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state got vld=%b busy=%b want 0/0", rsp_valid, busy); end
    checks++; if (rsp_result !== '0 || alu_a !== '0) begin errors++; $display("FAIL rstmid_regs got res=%h a=%h want 0/0", rsp_result, alu_a); end
    req_valid = 2'b11; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_ptr got=%b want=01", req_ready); end
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      tick;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_stale%0d got vld=%b busy=%b want 0/0", c, rsp_valid, busy); end
    end
  endtask

  task automatic test_illegal;
    rsp_ready = 1'b1;
    req_valid = 2'b01; set_req(0, 32'd4, 32'd4, 3'b110);
    tick; req_valid = '0; tick;
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== '0 || rsp_zero !== 1'b1) begin errors++; $display("FAIL illegal_rsp got vld=%b res=%0d z=%b want 1/0/1", rsp_valid, rsp_result, rsp_zero); end
`ifdef ALU_ARB_ILLEGAL_OP_EN
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL illegal_err got=%b want=1", rsp_err); end
`endif
    tick;
    req_valid = 2'b10; set_req(1, 32'd4, 32'd4, ALU_ADD);
    tick; req_valid = '0; tick;
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd8 || rsp_zero !== 1'b0 || rsp_id !== 1'b1) begin errors++; $display("FAIL legal_rsp got vld=%b res=%0d z=%b id=%0d want 1/8/0/1", rsp_valid, rsp_result, rsp_zero, rsp_id); end
`ifdef ALU_ARB_ILLEGAL_OP_EN
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL legal_err got=%b want=0", rsp_err); end
`endif
    tick;
  endtask

  // Transaction-level model: one op in flight, response two cycles after accept,
  // priority moves past whichever requester was last answered.
  task automatic test_random;
    int m_ptr, m_age, e_id, g;
    bit m_pend;
    logic [DW-1:0] e_a, e_b, e_res, va, vb;
    logic [2:0] e_f;
    logic [N-1:0] exp_rdy;
    logic exp_vld;
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; tick; rst = 1'b0;
    m_ptr = 0; m_pend = 0; m_age = 0; e_id = 0; e_a = '0; e_b = '0; e_f = '0; e_res = '0;
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++) begin
        va = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
        vb = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
        set_req(i, va, vb, 3'($urandom_range(0, 7)));
      end
      #1;
      exp_rdy = m_pend ? '0 : rr_exp(m_ptr, req_valid);
      exp_vld = m_pend && (m_age >= 2);
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, req_ready, exp_rdy); end
      checks++; if (rsp_valid !== exp_vld || busy !== m_pend) begin errors++; $display("FAIL rand_state c=%0d got vld=%b busy=%b want %b/%b", c, rsp_valid, busy, exp_vld, m_pend); end
      if (exp_vld) begin
        checks++; if (rsp_id !== 1'(e_id) || rsp_result !== e_res || rsp_zero !== (e_res == '0)) begin errors++; $display("FAIL rand_rsp c=%0d got id=%0d res=%h z=%b want id=%0d res=%h", c, rsp_id, rsp_result, rsp_zero, e_id, e_res); end
      end
      if (m_pend && m_age == 1) begin
        checks++; if (alu_a !== e_a || alu_b !== e_b || alu_func !== e_f) begin errors++; $display("FAIL rand_alu c=%0d got=%h/%h/%b want=%h/%h/%b", c, alu_a, alu_b, alu_func, e_a, e_b, e_f); end
      end
      if (!m_pend) begin
        if (|req_valid) begin
          g = 0;
          for (int i = 0; i < N; i++) if (exp_rdy[i]) g = i;
          m_pend = 1; m_age = 1; e_id = g;
          e_a = req_a[g*DW +: DW]; e_b = req_b[g*DW +: DW]; e_f = req_func[g*3 +: 3];
          e_res = alu_ref(e_a, e_b, e_f);
        end
      end else if (m_age >= 2) begin
        if (rsp_ready) begin
          m_pend = 0; m_ptr = (e_id + 1) % N;
        end
      end else begin
        m_age++;
      end
      tick;
    end
    req_valid = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_add;
    test_sub_slt;
    test_back_to_back;
    test_stall;
    test_reset_mid;
    test_illegal;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
